// File: rtl/prog_cntr_pkg.sv
// Shared fetch-path constants.
// Used by PC, branch and memory blocks.
package prog_cntr_pkg;
  localparam int PC_WIDTH = 8;
  localparam logic [PC_WIDTH-1:0] PC_RESET = '0;
endpackage

// File: rtl/prog_cntr_inc.sv
// WIDTH-bit +1 incrementer.
// Wraps modulo 2^WIDTH.
module prog_cntr_inc
  import prog_cntr_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  output logic [WIDTH-1:0] o_y
);
  assign o_y = i_a + WIDTH'(1);
endmodule

// File: rtl/prog_cntr.sv
// Program counter for the fetch path.
// Async clear, sync load, sync increment.
module prog_cntr
  import prog_cntr_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE =
    WIDTH'(PC_RESET)
) (
  input  logic             Clk,
  input  logic             nReset,
  output logic [WIDTH-1:0] Y,
  input  logic [WIDTH-1:0] A,
  input  logic             CountEn,
  input  logic             Load
);
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_next;

  prog_cntr_inc #(
    .WIDTH(WIDTH)
  ) u_inc (
    .i_a(r_y),
    .o_y(w_inc)
  );

  // Load outranks count; both may be high.
  always_comb begin
    w_next = r_y;
    if (Load)
      w_next = A;
    else if (CountEn)
      w_next = w_inc;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset)
      r_y <= RESET_VALUE;
    else
      r_y <= w_next;
  end

  assign Y = r_y;
endmodule

// File: tb/tb_prog_cntr.sv
// Scoreboard bench for prog_cntr.
// Expected PC values queued per edge.
module tb_prog_cntr;
  logic       Clk = 1'b0;
  logic       nReset = 1'b0;
  logic [7:0] Y;
  logic [7:0] A = '0;
  logic       CountEn = 1'b0;
  logic       Load = 1'b0;

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] m_pc = 8'd0;
  logic [7:0] sb_q[$];

  prog_cntr dut (
    .Clk(Clk),
    .nReset(nReset),
    .Y(Y),
    .A(A),
    .CountEn(CountEn),
    .Load(Load)
  );

  always #5 Clk = ~Clk;

  task automatic chk(
    input string tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    n_chk++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d want %0d",
               tag, obs, exp);
  endtask

  task automatic step(
    input string tag,
    input logic rst_n,
    input logic ld,
    input logic ce,
    input logic [7:0] a
  );
    logic [7:0] e;
    @(negedge Clk);
    nReset = rst_n;
    Load = ld;
    CountEn = ce;
    A = a;
    if (!rst_n)
      m_pc = 8'd0;
    else if (ld)
      m_pc = a;
    else if (ce)
      m_pc = m_pc + 8'd1;
    sb_q.push_back(m_pc);
    @(posedge Clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, Y, 8'hxx);
    end else begin
      e = sb_q.pop_front();
      chk(tag, Y, e);
    end
  endtask

  initial begin
    #2;
    chk("rst_async", Y, 8'd0);
    for (int i = 0; i < 3; i++)
      step("rst_hold", 1'b0, 1'b1, 1'b1, 8'd1);

    for (int i = 0; i < 3; i++)
      step("count", 1'b1, 1'b0, 1'b1, 8'hAA);

    for (int i = 0; i < 3; i++)
      step("hold", 1'b1, 1'b0, 1'b0, 8'h55);
    step("resume", 1'b1, 1'b0, 1'b1, 8'h00);

    step("load250", 1'b1, 1'b1, 1'b0, 8'd250);
    for (int i = 0; i < 7; i++)
      step("wrap", 1'b1, 1'b0, 1'b1, 8'h13);
    chk("wrap_end", Y, 8'd1);

    step("prio", 1'b1, 1'b1, 1'b1, 8'h40);
    step("post_prio", 1'b1, 1'b0, 1'b1, 8'h00);

    step("pre_rst", 1'b1, 1'b0, 1'b1, 8'h00);
    @(negedge Clk);
    #2;
    nReset = 1'b0;
    m_pc = 8'd0;
    #1;
    chk("mid_rst", Y, 8'd0);
    @(posedge Clk);
    #1;
    chk("mid_rst_edge", Y, 8'd0);
    step("release", 1'b1, 1'b0, 1'b1, 8'h00);
    step("after_rel", 1'b1, 1'b0, 1'b1, 8'h00);

    chk("sb_drained", 8'(sb_q.size()), 8'd0);
    $display("%0d/%0d checks passed",
             n_pass, n_chk);
    $finish;
  end
endmodule
